// File: rtl/rx_frame_packer_pkg.sv
// Shared constants and FSM encoding for the rx_frame_packer block.
package rx_frame_packer_pkg;

    // Default symbol width (highest code rate) and frame width (traceback depth).
    localparam int unsigned MAX_CODE_RATE   = 2;
    localparam int unsigned TRACEBACK_DEPTH = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/rx_sym_shifter.sv
// Fill side of the packer: MSB-first symbol shift register, symbol counter,
// flush zero-padding and the fill_full handshake to the output FSM.
// FRAME_W must be an integer multiple of SYM_W and strictly larger than it.
module rx_sym_shifter #(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned FRAME_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sym_valid,
    input  logic [SYM_W-1:0]   sym,
    input  logic               flush,
    input  logic               take,
    output logic               sym_ready,
    output logic [FRAME_W-1:0] fill_buf,
    output logic               fill_full
);

    localparam int unsigned N    = FRAME_W / SYM_W;
    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(N);

    logic [CntW-1:0]    cnt;
    logic [CntW-1:0]    eff_cnt;
    logic               accept;
    logic               do_pad;
    logic [FRAME_W-1:0] shifted;
    logic [FRAME_W-1:0] next_buf;
    logic [FRAME_W-1:0] pad_buf;
    int unsigned        pad_shift;

    assign sym_ready = !fill_full;
    assign accept    = sym_valid && !fill_full;
    assign shifted   = {fill_buf[FRAME_W-SYM_W-1:0], sym};
    // Count including a symbol accepted in the same cycle as the flush.
    assign eff_cnt   = cnt + CntW'(accept);
    assign do_pad    = flush && (eff_cnt != '0) && (eff_cnt != FullCnt);

    // Padded frame: buffer including this cycle's symbol, left-aligned with zero LSBs.
    always_comb begin
        next_buf  = accept ? shifted : fill_buf;
        pad_shift = (N - 32'(eff_cnt)) * SYM_W;
        pad_buf   = next_buf << pad_shift;
    end

    // Fill buffer, counter and fill_full; flush is ignored while a frame is waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_buf  <= '0;
            cnt       <= '0;
            fill_full <= 1'b0;
        end else if (take) begin
            fill_full <= 1'b0;
        end else if (!fill_full) begin
            if (do_pad) begin
                fill_buf  <= pad_buf;
                cnt       <= '0;
                fill_full <= 1'b1;
            end else if (accept) begin
                fill_buf <= shifted;
                if (cnt == LastCnt) begin
                    cnt       <= '0;
                    fill_full <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rx_frame_packer.sv
// Packs received channel symbols into decoder frames and hands each frame to the
// Viterbi decoder, holding enable until done or until the watchdog aborts it.
module rx_frame_packer
    import rx_frame_packer_pkg::*;
#(
    parameter int unsigned SYM_W       = MAX_CODE_RATE,
    parameter int unsigned FRAME_W     = TRACEBACK_DEPTH,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_sym_valid,
    input  logic [SYM_W-1:0]   i_sym,
    output logic               o_sym_ready,
    input  logic               i_flush,
    input  logic               i_dec_done,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_dec_en,
    output logic [15:0]        o_frame_cnt,
    output logic               o_timeout
);

    localparam int unsigned WdogW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYC - 1);

    fsm_state_e         state;
    logic [WdogW-1:0]   wdog;
    logic [FRAME_W-1:0] fill_buf;
    logic               fill_full;
    logic               take;

    // The hold register takes the filled frame only when the decoder is free.
    assign take = (state == StIdle) && fill_full;

    rx_sym_shifter #(
        .SYM_W   (SYM_W),
        .FRAME_W (FRAME_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (i_sym_valid),
        .sym       (i_sym),
        .flush     (i_flush),
        .take      (take),
        .sym_ready (o_sym_ready),
        .fill_buf  (fill_buf),
        .fill_full (fill_full)
    );

    // Output FSM with registered frame, enable, frame counter and watchdog.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= StIdle;
            o_frame     <= '0;
            o_dec_en    <= 1'b0;
            o_frame_cnt <= '0;
            o_timeout   <= 1'b0;
            wdog        <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (fill_full) begin
                        o_frame  <= fill_buf;
                        wdog     <= '0;
                        o_dec_en <= 1'b1;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (i_dec_done) begin
                        o_dec_en    <= 1'b0;
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        state       <= StIdle;
                    end else begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (i_dec_done) begin
                        o_dec_en    <= 1'b0;
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        state       <= StIdle;
                    end else if (wdog == WdogLast) begin
                        o_dec_en  <= 1'b0;
                        o_timeout <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    o_dec_en <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_packer.sv
// Directed bench for rx_frame_packer with SYM_W=2, FRAME_W=8, TIMEOUT_CYC=16.
module tb_rx_frame_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_sym_valid = 1'b0;
    logic [1:0]  i_sym = '0;
    logic        o_sym_ready;
    logic        i_flush = 1'b0;
    logic        i_dec_done = 1'b0;
    logic [7:0]  o_frame;
    logic        o_dec_en;
    logic [15:0] o_frame_cnt;
    logic        o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    rx_frame_packer #(
        .SYM_W       (2),
        .FRAME_W     (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sym_valid (i_sym_valid),
        .i_sym       (i_sym),
        .o_sym_ready (o_sym_ready),
        .i_flush     (i_flush),
        .i_dec_done  (i_dec_done),
        .o_frame     (o_frame),
        .o_dec_en    (o_dec_en),
        .o_frame_cnt (o_frame_cnt),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present one symbol (optionally with flush) until accepted; returns just after
    // the accepting edge.
    task automatic send(input logic [1:0] s, input logic fl);
        int guard;
        guard = 0;
        i_sym_valid = 1'b1;
        i_sym       = s;
        i_flush     = fl;
        while (!o_sym_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("send_ready_timeout", 32'(o_sym_ready), 32'd1);
        step();
        i_sym_valid = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic pulse_done();
        i_dec_done = 1'b1;
        step();
        i_dec_done = 1'b0;
    endtask

    // Send up to four symbols (first in syms[7:6]) with per-symbol idle gaps,
    // flushing on the last accept.
    task automatic send_seq(input logic [7:0] syms, input int nsym, input logic [15:0] gaps);
        logic [7:0]  sv;
        logic [15:0] gv;
        sv = syms;
        gv = gaps;
        for (int i = 0; i < nsym; i++) begin
            idle(int'(gv[15-4*i -: 4]));
            send(sv[7-2*i -: 2], i == nsym - 1);
        end
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_frame", 32'(o_frame), 32'h0);
        check("rst_dec_en", 32'(o_dec_en), 32'd0);
        check("rst_cnt", 32'(o_frame_cnt), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_ready", 32'(o_sym_ready), 32'd1);
        rst = 1'b1;
        step();

        // 1: back-to-back full frame
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        send(2'b00, 1'b0);
        check("t1_ready_full", 32'(o_sym_ready), 32'd0);
        check("t1_en_t1", 32'(o_dec_en), 32'd0);
        step();
        check("t1_frame", 32'(o_frame), 32'h6C);
        check("t1_en_t2", 32'(o_dec_en), 32'd1);
        check("t1_ready_back", 32'(o_sym_ready), 32'd1);
        idle(2);
        pulse_done();
        check("t1_en_off", 32'(o_dec_en), 32'd0);
        check("t1_cnt", 32'(o_frame_cnt), 32'd1);
        check("t1_frame_hold", 32'(o_frame), 32'h6C);

        // 2: partial frame closed by a separate flush, then flush with empty buffer
        send(2'b11, 1'b0);
        send(2'b01, 1'b0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        step();
        check("t2_frame", 32'(o_frame), 32'hD0);
        check("t2_en", 32'(o_dec_en), 32'd1);
        pulse_done();
        check("t2_cnt", 32'(o_frame_cnt), 32'd2);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        idle(2);
        check("t2_empty_flush_en", 32'(o_dec_en), 32'd0);
        check("t2_empty_flush_ready", 32'(o_sym_ready), 32'd1);

        // 3: second frame fills while first decodes, backpressure until done
        send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        step();
        check("t3_frame_a", 32'(o_frame), 32'h1B);
        send(2'b11, 1'b0);
        send(2'b11, 1'b0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        check("t3_ready_low", 32'(o_sym_ready), 32'd0);
        step();
        check("t3_ready_held", 32'(o_sym_ready), 32'd0);
        check("t3_frame_a_held", 32'(o_frame), 32'h1B);
        check("t3_en_held", 32'(o_dec_en), 32'd1);
        pulse_done();
        check("t3_en_gap", 32'(o_dec_en), 32'd0);
        check("t3_cnt_a", 32'(o_frame_cnt), 32'd3);
        step();
        check("t3_frame_b", 32'(o_frame), 32'hF1);
        check("t3_en_b", 32'(o_dec_en), 32'd1);
        check("t3_ready_back", 32'(o_sym_ready), 32'd1);
        pulse_done();
        check("t3_cnt_b", 32'(o_frame_cnt), 32'd4);

        // 4: watchdog abort after 16 WAIT cycles
        send(2'b10, 1'b0);
        send(2'b10, 1'b0);
        send(2'b10, 1'b0);
        send(2'b10, 1'b0);
        step();
        check("t4_frame", 32'(o_frame), 32'hAA);
        idle(16);
        check("t4_en_last_wait", 32'(o_dec_en), 32'd1);
        check("t4_timeout_pre", 32'(o_timeout), 32'd0);
        step();
        check("t4_en_abort", 32'(o_dec_en), 32'd0);
        check("t4_timeout", 32'(o_timeout), 32'd1);
        check("t4_cnt", 32'(o_frame_cnt), 32'd4);

        // 5: reset mid-fill, then reset during WAIT
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t5_rst_frame", 32'(o_frame), 32'h0);
        check("t5_rst_timeout", 32'(o_timeout), 32'd0);
        check("t5_rst_cnt", 32'(o_frame_cnt), 32'd0);
        check("t5_rst_ready", 32'(o_sym_ready), 32'd1);
        send(2'b11, 1'b0);
        send(2'b10, 1'b0);
        send(2'b01, 1'b0);
        send(2'b00, 1'b0);
        step();
        check("t5_frame_fresh", 32'(o_frame), 32'hE4);
        idle(2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t5_wait_rst_en", 32'(o_dec_en), 32'd0);
        check("t5_wait_rst_frame", 32'(o_frame), 32'h0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        step();
        check("t5_frame_after", 32'(o_frame), 32'h1B);
        pulse_done();
        check("t5_cnt", 32'(o_frame_cnt), 32'd1);

        // 6: gapped symbols with flush on the final accept cycle
        send_seq(8'b10_01_11_00, 3, 16'h0210);
        step();
        check("t6_pad_frame", 32'(o_frame), 32'h9C);
        pulse_done();
        check("t6_pad_cnt", 32'(o_frame_cnt), 32'd2);
        send_seq(8'b01_00_11_10, 4, 16'h1032);
        step();
        check("t6_full_frame", 32'(o_frame), 32'h4E);
        pulse_done();
        check("t6_full_cnt", 32'(o_frame_cnt), 32'd3);
        idle(2);
        check("t6_no_extra", 32'(o_dec_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
